jtcontra_palmix: RTL

- Pixel back end that consumes the two 7-bit tile/object pixel streams from the graphics chips.
- Resolves layer priority and transparency, then looks the winning pixel up in a CPU-writable 256-byte palette RAM holding 128 colours × 2 bytes.
- Emits 5-bit RGB with blanking delayed to match the pipeline.
- Sits between the two graphics chips and the credits overlay / video output.

---
 rtl/jtcontra_palmix.sv | 137 +++++++++++++
 1 files changed

// File: rtl/jtcontra_palmix.sv
// Pixel back end for the two graphics chips: resolves priority/transparency between the
// two 7-bit layer pixels, fetches the winning colour from a CPU-writable 256-byte palette
// (128 entries x {lo, hi}) and drives 5-bit RGB with blanking delayed to match.
//
// Ports:
//   clk, rst            48 MHz clock, synchronous active-high reset
//   pxl2_cen, pxl_cen   12 MHz / 6 MHz clock enables (pxl_cen always lands on a pxl2_cen)
//   cpu_cen             CPU bus clock enable (qualifies writes only)
//   LHBL, LVBL          active-low blanking in; LHBL_dly/LVBL_dly aligned with RGB
//   pal_cs, cpu_rnw,
//   cpu_addr, cpu_dout  CPU palette port; pal_dout is the registered read data
//   prio                0: gfx1 on top, 1: gfx2 on top
//   gfx1_pxl, gfx2_pxl  layer pixels {pal[2:0], colour[3:0]}
//   red, green, blue    5-bit colour out
module jtcontra_palmix #(
    parameter bit BLANK_OUT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl2_cen,
    input  logic       pxl_cen,
    input  logic       cpu_cen,
    input  logic       LHBL,
    input  logic       LVBL,
    output logic       LHBL_dly,
    output logic       LVBL_dly,
    input  logic       pal_cs,
    input  logic       cpu_rnw,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_dout,
    output logic [7:0] pal_dout,
    input  logic       prio,
    input  logic [6:0] gfx1_pxl,
    input  logic [6:0] gfx2_pxl,
    output logic [4:0] red,
    output logic [4:0] green,
    output logic [4:0] blue
);

    typedef enum logic [0:0] {
        StFetchLo,
        StFetchHi
    } fetch_state_e;

    fetch_state_e state_q, state_d;

    logic [7:0]  pal_mem [256];
    logic [6:0]  idx_q;
    logic [7:0]  lo_q;
    logic [14:0] rgb_q;
    logic [1:0]  hb_q, vb_q;
    logic [7:0]  pal_dout_q;

    logic [6:0]  top_pxl, bot_pxl, sel_pxl;
    logic [7:0]  vid_addr;
    logic [7:0]  vid_data;
    logic        blank_next;
    logic [14:0] rgb_next;

    // Layer priority: fall back to the bottom layer when the top one is transparent, so
    // two transparent layers still show the bottom layer's background pen.
    always_comb begin
        top_pxl = prio ? gfx2_pxl : gfx1_pxl;
        bot_pxl = prio ? gfx1_pxl : gfx2_pxl;
        sel_pxl = (top_pxl[3:0] != 4'd0) ? top_pxl : bot_pxl;
    end

    // Fetch FSM: every pxl_cen forces the low-byte phase so a stray or missing enable can
    // only corrupt one pixel, never the phase alignment.
    always_comb begin
        state_d = state_q;
        if (pxl_cen) begin
            state_d = StFetchLo;
        end else if (pxl2_cen) begin
            state_d = StFetchHi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetchLo;
        end else begin
            state_q <= state_d;
        end
    end

    // Video read port. The read is taken at the same edge as any CPU write, so a write to
    // the byte being fetched is seen by the next fetch (read-first).
    always_comb begin
        vid_addr = {idx_q, state_q == StFetchHi};
        vid_data = pal_mem[vid_addr];
    end

    // {hi, lo} -> {R, G, B}; hi arrives straight from the RAM on the pxl_cen edge.
    always_comb begin
        blank_next = BLANK_OUT && !(hb_q[0] && vb_q[0]);
        rgb_next   = {lo_q[4:0], vid_data[1:0], lo_q[7:5], vid_data[6:2]};
        if (blank_next) begin
            rgb_next = 15'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (pal_cs && !cpu_rnw && cpu_cen) begin
            pal_mem[cpu_addr] <= cpu_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= 7'd0;
            lo_q       <= 8'd0;
            rgb_q      <= 15'd0;
            hb_q       <= 2'd0;
            vb_q       <= 2'd0;
            pal_dout_q <= 8'd0;
        end else begin
            pal_dout_q <= pal_mem[cpu_addr];
            if (pxl_cen) begin
                idx_q <= sel_pxl;
                hb_q  <= {hb_q[0], LHBL};
                vb_q  <= {vb_q[0], LVBL};
                rgb_q <= rgb_next;
            end else if (pxl2_cen && state_q == StFetchLo) begin
                lo_q <= vid_data;
            end
        end
    end

    assign red      = rgb_q[14:10];
    assign green    = rgb_q[9:5];
    assign blue     = rgb_q[4:0];
    assign LHBL_dly = hb_q[1];
    assign LVBL_dly = vb_q[1];
    assign pal_dout = pal_dout_q;

endmodule
